regalu_mc: RTL and testbench

- Parametrised multi-cycle execute unit: register file, operand-source mux and ALU with a registered result stage and write-back to the register file.
- Adds an iterative shift-add multiplier, a valid/ready issue handshake and a result-valid strobe.
- Sits between the decode/control block and the write-back path of the CPU datapath.
- Exposes a0 (x10) for testbench checking.

---
 rtl/regalu_mc.sv | 133 +++++++++++++
 tb/tb_regalu_mc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regalu_mc.sv
// rtl/regalu_mc.sv - multi-cycle execute unit: register file, ALU, shift-add multiplier
// Non-MUL ops complete in one cycle; MUL iterates one multiplier bit per cycle.
module regalu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_INDEX   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  reg_write,
  input  logic                  alu_src,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] imm_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  eq,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR  = ADDR_WIDTH'(A0_INDEX);
  localparam logic [SHW-1:0]        LAST_CNT = SHW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [SHW-1:0]        r_count;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_we;

  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic [DATA_WIDTH-1:0] w_op2;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [SHW-1:0]        w_shamt;
  logic                  w_accept;
  logic                  w_is_mul;

  assign w_op1    = (rs1 == '0) ? '0 : r_regs[rs1];
  assign w_rd2    = (rs2 == '0) ? '0 : r_regs[rs2];
  assign w_op2    = alu_src ? imm_op : w_rd2;
  assign w_shamt  = w_op2[SHW-1:0];
  assign w_is_mul = (alu_ctrl == 4'b1010);

  assign issue_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = issue_valid && issue_ready;
  assign busy        = (r_state == S_MUL);
  assign a0          = r_regs[A0_ADDR];

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      4'b0000: w_alu = w_op1 + w_op2;
      4'b0001: w_alu = w_op1 - w_op2;
      4'b0010: w_alu = w_op1 & w_op2;
      4'b0011: w_alu = w_op1 | w_op2;
      4'b0100: w_alu = w_op1 ^ w_op2;
      4'b0101: w_alu = w_op1 << w_shamt;
      4'b0110: w_alu = w_op1 >> w_shamt;
      4'b0111: w_alu = DATA_WIDTH'($signed(w_op1) >>> w_shamt);
      4'b1000: w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
      4'b1001: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_op1 < w_op2};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      eq           <= 1'b0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_rd         <= '0;
      r_we         <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            eq <= (w_op1 == w_op2);
            if (w_is_mul) begin
              r_mcand  <= w_op1;
              r_mplier <= w_op2;
              r_acc    <= '0;
              r_count  <= '0;
              r_rd     <= rd;
              r_we     <= reg_write;
              r_state  <= S_MUL;
            end else begin
              result       <= w_alu;
              result_valid <= 1'b1;
              if (reg_write && (rd != '0)) r_regs[rd] <= w_alu;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          // Last multiplier bit: the accumulated sum is the final product.
          if (r_count == LAST_CNT) begin
            result       <= w_acc_next;
            result_valid <= 1'b1;
            if (r_we && (r_rd != '0)) r_regs[r_rd] <= w_acc_next;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regalu_mc.sv
// tb/tb_regalu_mc.sv - randomized self-checking bench for regalu_mc against a reference model
module tb_regalu_mc;
  localparam int DW = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SRL = 4'd6, OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [4:0]    rs1, rs2, rd;
  logic          reg_write, alu_src;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] imm_op;
  logic [DW-1:0] result;
  logic          result_valid, eq, busy;
  logic [DW-1:0] a0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] m_regs [32];

  always #5 clk = ~clk;

  regalu_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(5), .A0_INDEX(10)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .imm_op(imm_op), .result(result), .result_valid(result_valid),
    .eq(eq), .busy(busy), .a0(a0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int sh;
    logic [63:0] prod;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return a[DW-1] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[DW-1:0];
      end
      default: return '0;
    endcase
  endfunction

  task automatic do_op(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_rd,
                       input logic a_we, input logic a_src, input logic [3:0] a_op,
                       input logic [DW-1:0] a_imm, input string tag);
    logic [DW-1:0] op1, op2, exp;
    int cyc, bad;
    op1 = m_regs[a_rs1];
    op2 = a_src ? a_imm : m_regs[a_rs2];
    exp = ref_alu(a_op, op1, op2);
    cyc = 0;
    while (!issue_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!issue_ready) check_eq({tag, "/ready_timeout"}, 64'(issue_ready), 64'd1);
    rs1 = a_rs1; rs2 = a_rs2; rd = a_rd; reg_write = a_we; alu_src = a_src;
    alu_ctrl = a_op; imm_op = a_imm; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    if (a_op == OP_MUL) begin
      check_eq({tag, "/mul_busy"}, 64'(busy), 64'd1);
      check_eq({tag, "/mul_ready"}, 64'(issue_ready), 64'd0);
      check_eq({tag, "/mul_rv_early"}, 64'(result_valid), 64'd0);
      cyc = 0;
      bad = 0;
      while (!result_valid && cyc < DW + 10) begin
        // Stray requests while busy must be ignored.
        if (cyc < 3) begin
          issue_valid = 1'b1;
          rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
          alu_ctrl = 4'($urandom); imm_op = $urandom; reg_write = 1'b1;
        end else begin
          issue_valid = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
        if (!result_valid && (!busy || issue_ready)) bad++;
      end
      issue_valid = 1'b0;
      check_eq({tag, "/mul_latency"}, 64'(cyc), 64'(DW));
      check_eq({tag, "/mul_busy_cycles_bad"}, 64'(bad), 64'd0);
    end
    check_eq({tag, "/rv"}, 64'(result_valid), 64'd1);
    check_eq({tag, "/result"}, 64'(result), 64'(exp));
    check_eq({tag, "/eq"}, 64'(eq), 64'(op1 == op2));
    check_eq({tag, "/busy_done"}, 64'(busy), 64'd0);
    check_eq({tag, "/ready_done"}, 64'(issue_ready), 64'd1);
    if (a_we && a_rd != 5'd0) m_regs[a_rd] = exp;
    check_eq({tag, "/a0"}, 64'(a0), 64'(m_regs[10]));
  endtask

  initial begin
    int valids;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    rst = 1'b1; issue_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    reg_write = 1'b0; alu_src = 1'b0; alu_ctrl = '0; imm_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/result", 64'(result), 64'd0);
    check_eq("rst/rv", 64'(result_valid), 64'd0);
    check_eq("rst/eq", 64'(eq), 64'd0);
    check_eq("rst/a0", 64'(a0), 64'd0);
    check_eq("rst/busy", 64'(busy), 64'd0);
    check_eq("rst/ready_in_rst", 64'(issue_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst/ready_after", 64'(issue_ready), 64'd1);

    do_op(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, OP_ADD, 32'd5, "add_x10");
    check_eq("add_x10/const", 64'(result), 64'd5);

    do_op(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, OP_ADD, 32'd7, "add_x1");
    do_op(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, OP_ADD, 32'd0, "add_dep");
    check_eq("add_dep/const", 64'(result), 64'd14);
    do_op(5'd2, 5'd2, 5'd3, 1'b1, 1'b0, OP_SUB, 32'd0, "sub_self");
    check_eq("sub_self/const_eq", 64'(eq), 64'd1);

    do_op(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, OP_ADD, 32'h8000_0000, "ld_min");
    do_op(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, OP_SRA, 32'd4, "sra");
    check_eq("sra/const", 64'(result), 64'hF800_0000);
    do_op(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, OP_SRL, 32'd4, "srl");
    check_eq("srl/const", 64'(result), 64'h0800_0000);
    do_op(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, OP_ADD, 32'hFFFF_FFFF, "ld_m1");
    do_op(5'd7, 5'd0, 5'd8, 1'b1, 1'b1, OP_SLT, 32'd1, "slt");
    check_eq("slt/const", 64'(result), 64'd1);
    do_op(5'd7, 5'd0, 5'd8, 1'b1, 1'b1, OP_SLTU, 32'd1, "sltu");
    check_eq("sltu/const", 64'(result), 64'd0);

    do_op(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, OP_ADD, 32'd7, "ld_7");
    do_op(5'd8, 5'd0, 5'd10, 1'b1, 1'b1, OP_MUL, 32'd6, "mul_42");
    check_eq("mul_42/const", 64'(result), 64'd42);
    check_eq("mul_42/a0_const", 64'(a0), 64'd42);
    do_op(5'd7, 5'd0, 5'd9, 1'b1, 1'b1, OP_MUL, 32'd2, "mul_wrap");
    check_eq("mul_wrap/const", 64'(result), 64'hFFFF_FFFE);

    do_op(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, OP_ADD, 32'd9, "add_x0");
    check_eq("add_x0/const", 64'(result), 64'd9);
    do_op(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, OP_ADD, 32'd0, "read_x0");
    check_eq("read_x0/const", 64'(result), 64'd0);

    // Reset in the middle of a multiply must abort it silently.
    do_op(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, OP_ADD, 32'd3, "ld_3");
    rs1 = 5'd6; alu_src = 1'b1; imm_op = 32'd3; alu_ctrl = OP_MUL; rd = 5'd5;
    reg_write = 1'b1; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    check_eq("rstmul/busy", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmul/ready_in_rst", 64'(issue_ready), 64'd0);
    check_eq("rstmul/busy_cleared", 64'(busy), 64'd0);
    check_eq("rstmul/result_cleared", 64'(result), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rstmul/ready_after", 64'(issue_ready), 64'd1);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    valids = 0;
    for (int i = 0; i < DW + 4; i++) begin
      @(posedge clk); #1;
      if (result_valid) valids++;
    end
    check_eq("rstmul/no_rv", 64'(valids), 64'd0);
    do_op(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, OP_ADD, 32'd0, "rstmul_x5");
    check_eq("rstmul_x5/const", 64'(result), 64'd0);

    for (int i = 1; i < 8; i++)
      do_op(5'd0, 5'd0, 5'(i), 1'b1, 1'b1, OP_ADD, $urandom, "seed");
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] imm;
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      do_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 10)),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), imm, "rand");
    end
    @(posedge clk); #1;
    check_eq("idle/rv_low", 64'(result_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
